// File: rtl/i2c_bus_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_bus_scheduler_if
//  Description : Bus-side signal bundle of the I2C bus scheduler.
//                master : requester / pad side (drives request and pad levels)
//                slave  : scheduler side (drives grant, busy, timeout, lockout)
//  Signals     : request   [REQUEST_COUNT] per-requester bus request
//                scl_input / sda_input     raw asynchronous pad levels
//                grant     [REQUEST_COUNT] one-hot or zero grant
//                busy                      scheduler not idle
//                timeout                   one-cycle forced-revocation pulse
//                lockout   [REQUEST_COUNT] requesters barred after a timeout
//  Revision    : 1.0 - initial release
// ============================================================================
interface i2c_bus_scheduler_if #(
    parameter int REQUEST_COUNT = 4
);
    logic [REQUEST_COUNT-1:0] request;
    logic                     scl_input;
    logic                     sda_input;
    logic [REQUEST_COUNT-1:0] grant;
    logic                     busy;
    logic                     timeout;
    logic [REQUEST_COUNT-1:0] lockout;

    modport master (
        output request, scl_input, sda_input,
        input  grant, busy, timeout, lockout
    );

    modport slave (
        input  request, scl_input, sda_input,
        output grant, busy, timeout, lockout
    );
endinterface
`default_nettype wire

// File: rtl/i2c_bus_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_bus_scheduler
//  Description : Round-robin scheduler granting a shared I2C bus to one of
//                REQUEST_COUNT requesters. Enforces a bus-free gap between
//                grants and revokes a grant held for TIMEOUT_CYCLES, locking
//                the offender out until it drops its request.
//  Ports       : clock    - single clock
//                reset_n  - asynchronous active-low reset
//                bus      - slave modport of i2c_bus_scheduler_if
//  Parameters  : REQUEST_COUNT (2..8), GAP_CYCLES (>= 2), TIMEOUT_CYCLES
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_bus_scheduler #(
    parameter int REQUEST_COUNT  = 4,
    parameter int GAP_CYCLES     = 1000,
    parameter int TIMEOUT_CYCLES = 200_000_000
) (
    input  wire logic          clock,
    input  wire logic          reset_n,
    i2c_bus_scheduler_if.slave bus
);

    localparam int C_IDX_W   = $clog2(REQUEST_COUNT);
    localparam int C_MAX_CNT = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int C_CNT_W   = $clog2(C_MAX_CNT + 1);

    localparam logic [C_CNT_W-1:0] C_CNT_ONE   = C_CNT_W'(1);
    localparam logic [C_CNT_W-1:0] C_HOLD_LAST = C_CNT_W'(TIMEOUT_CYCLES - 1);
    // The IDLE arbitration cycle is the last zero-grant cycle of the gap, so
    // GAP/RECOVER themselves last GAP_CYCLES-1 cycles.
    localparam logic [C_CNT_W-1:0] C_GAP_LAST  = C_CNT_W'(GAP_CYCLES - 2);
    localparam logic [C_IDX_W-1:0] C_IDX_ONE   = C_IDX_W'(1);
    localparam logic [C_IDX_W-1:0] C_LAST_INIT = C_IDX_W'(REQUEST_COUNT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANTED = 2'd1,
        S_GAP     = 2'd2,
        S_RECOVER = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [1:0]               r_scl_sync;
    logic [1:0]               r_sda_sync;
    logic [REQUEST_COUNT-1:0] r_grant;
    logic [REQUEST_COUNT-1:0] w_grant_nxt;
    logic [REQUEST_COUNT-1:0] r_lockout;
    logic [REQUEST_COUNT-1:0] w_lock_set;
    logic                     r_timeout;
    logic                     w_timeout_nxt;
    logic [C_CNT_W-1:0]       r_cnt;
    logic [C_CNT_W-1:0]       w_cnt_nxt;
    logic [C_IDX_W-1:0]       r_winner;
    logic [C_IDX_W-1:0]       w_winner_nxt;
    logic [C_IDX_W-1:0]       r_last;
    logic [C_IDX_W-1:0]       w_last_nxt;
    logic [C_IDX_W-1:0]       w_scan;
    logic [C_IDX_W-1:0]       w_pick;
    logic                     w_found;
    logic                     w_bus_idle;
    logic [REQUEST_COUNT-1:0] w_eligible;

    // Pad synchronizers reset to 1 so an idle bus is assumed out of reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
        end else begin
            r_scl_sync <= {r_scl_sync[0], bus.scl_input};
            r_sda_sync <= {r_sda_sync[0], bus.sda_input};
        end
    end

    assign w_bus_idle = r_scl_sync[1] & r_sda_sync[1];
    assign w_eligible = bus.request & ~r_lockout;

    // Round-robin search: walk from last_winner+1 upward with wrap-around and
    // take the first eligible requester.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_scan  = r_last;
        for (int k = 0; k < REQUEST_COUNT; k++) begin
            w_scan = (w_scan == C_LAST_INIT) ? '0 : w_scan + C_IDX_ONE;
            if (!w_found && w_eligible[w_scan]) begin
                w_found = 1'b1;
                w_pick  = w_scan;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_timeout <= 1'b0;
            r_lockout <= '0;
            r_cnt     <= '0;
            r_winner  <= '0;
            r_last    <= C_LAST_INIT;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_timeout <= w_timeout_nxt;
            // A set only happens while the request is high, so set and clear
            // can never collide on the same bit.
            r_lockout <= w_lock_set | (r_lockout & bus.request);
            r_cnt     <= w_cnt_nxt;
            r_winner  <= w_winner_nxt;
            r_last    <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_timeout_nxt = 1'b0;
        w_lock_set    = '0;
        w_cnt_nxt     = r_cnt;
        w_winner_nxt  = r_winner;
        w_last_nxt    = r_last;
        case (r_state)
            S_IDLE: begin
                w_grant_nxt = '0;
                w_cnt_nxt   = '0;
                if (w_bus_idle && w_found) begin
                    w_grant_nxt[w_pick] = 1'b1;
                    w_winner_nxt        = w_pick;
                    w_last_nxt          = w_pick;
                    w_state_nxt         = S_GRANTED;
                end
            end
            S_GRANTED: begin
                // A release in the limit cycle wins over the timeout.
                if (!bus.request[r_winner]) begin
                    w_grant_nxt = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_GAP;
                end else if (r_cnt == C_HOLD_LAST) begin
                    w_grant_nxt          = '0;
                    w_cnt_nxt            = '0;
                    w_timeout_nxt        = 1'b1;
                    w_lock_set[r_winner] = 1'b1;
                    w_state_nxt          = S_RECOVER;
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_ONE;
                end
            end
            S_GAP, S_RECOVER: begin
                w_grant_nxt = '0;
                if (r_cnt >= C_GAP_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_ONE;
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.grant   = r_grant;
    assign bus.busy    = (r_state != S_IDLE);
    assign bus.timeout = r_timeout;
    assign bus.lockout = r_lockout;

endmodule
`default_nettype wire

// File: tb/tb_i2c_bus_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_bus_scheduler
//  Description : Self-checking bench for i2c_bus_scheduler with
//                REQUEST_COUNT=4, GAP_CYCLES=4, TIMEOUT_CYCLES=64.
//                Expected grants (and the zero-grant gap preceding them) are
//                queued as stimulus is driven and popped by a monitor when
//                the DUT raises a grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_bus_scheduler;

    typedef struct {
        logic [3:0] grant;
        int         gap;    // expected zero-grant cycles before it, -1 = any
    } exp_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];

    i2c_bus_scheduler_if #(.REQUEST_COUNT(4)) bus_if();

    i2c_bus_scheduler #(
        .REQUEST_COUNT (4),
        .GAP_CYCLES    (4),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus_if)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Monitor / scoreboard consumer.
    logic [3:0] mon_prev = 4'b0;
    int         mon_zrun = 0;
    bit         mon_seen = 1'b0;
    exp_t       mon_e;

    always @(negedge clock) begin
        if (!reset_n) begin
            mon_prev = 4'b0;
            mon_zrun = 0;
            mon_seen = 1'b0;
        end else begin
            n_checks++;
            if ($countones(bus_if.grant) > 1) begin
                n_errors++;
                $display("FAIL grant_onehot: got %b required at most one bit", bus_if.grant);
            end
            if (bus_if.grant != 4'b0 && mon_prev == 4'b0) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_grant: got %b required none", bus_if.grant);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (bus_if.grant !== mon_e.grant) begin
                        n_errors++;
                        $display("FAIL sb_grant: got %b required %b", bus_if.grant, mon_e.grant);
                    end
                    if (mon_e.gap >= 0 && mon_seen) begin
                        n_checks++;
                        if (mon_zrun != mon_e.gap) begin
                            n_errors++;
                            $display("FAIL sb_gap: got %0d zero cycles required %0d", mon_zrun, mon_e.gap);
                        end
                    end
                end
                mon_seen = 1'b1;
                mon_zrun = 0;
            end else if (bus_if.grant == 4'b0 && mon_seen) begin
                mon_zrun++;
            end
            mon_prev = bus_if.grant;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input logic [3:0] g, input int gap);
        exp_t e;
        e.grant = g;
        e.gap   = gap;
        sb_q.push_back(e);
    endtask

    task automatic wait_grant(output logic [3:0] g, output int cyc, input int budget);
        cyc = 0;
        while (bus_if.grant == 4'b0 && cyc < budget) begin
            tick();
            cyc++;
        end
        g = bus_if.grant;
    endtask

    task automatic wait_idle(output bit ok, input int budget);
        int n = 0;
        while (bus_if.busy && n < budget) begin
            tick();
            n++;
        end
        ok = !bus_if.busy;
    endtask

    task automatic test_reset();
        bus_if.request   = 4'b0;
        bus_if.scl_input = 1'b1;
        bus_if.sda_input = 1'b1;
        reset_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if (bus_if.grant !== 4'b0 || bus_if.busy !== 1'b0 || bus_if.timeout !== 1'b0 ||
            bus_if.lockout !== 4'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: got grant=%b busy=%b timeout=%b lockout=%b required all zero",
                     bus_if.grant, bus_if.busy, bus_if.timeout, bus_if.lockout);
        end
        reset_n = 1'b1;
        tick();
        n_checks++;
        if (bus_if.grant !== 4'b0 || bus_if.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL post_reset_idle: got grant=%b busy=%b required 0000/0", bus_if.grant, bus_if.busy);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] rr_exp [5];
        logic [3:0] g;
        int         cyc;
        bit         ok;
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        push_exp(4'b0001, -1);
        for (int i = 1; i < 5; i++) push_exp(rr_exp[i], 4);
        bus_if.request = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_grant(g, cyc, 20);
            n_checks++;
            if (g !== rr_exp[i]) begin
                n_errors++;
                $display("FAIL rr_grant_%0d: got %b required %b", i, g, rr_exp[i]);
            end
            if (i == 0) begin
                n_checks++;
                if (cyc != 1) begin
                    n_errors++;
                    $display("FAIL rr_latency: got %0d cycles required 1", cyc);
                end
            end
            repeat (3) tick();
            bus_if.request = bus_if.request & ~g;
            tick();
            tick();
            if (i < 4) bus_if.request = bus_if.request | g;
        end
        bus_if.request = 4'b0;
        wait_idle(ok, 20);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL rr_idle: got busy=%b required 0", bus_if.busy);
        end
    endtask

    task automatic test_bus_busy();
        bit ok;
        bit bad = 1'b0;
        wait_idle(ok, 20);
        bus_if.sda_input = 1'b0;
        repeat (3) tick();
        bus_if.request = 4'b0100;
        push_exp(4'b0100, -1);
        repeat (5) begin
            tick();
            if (bus_if.grant !== 4'b0 || bus_if.busy !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_errors++;
            $display("FAIL busy_bus_hold: got grant=%b busy=%b required 0000/0", bus_if.grant, bus_if.busy);
        end
        bus_if.sda_input = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus_if.grant !== 4'b0) begin
            n_errors++;
            $display("FAIL busy_bus_sync: got %b required 0000 two cycles after release", bus_if.grant);
        end
        tick();
        n_checks++;
        if (bus_if.grant !== 4'b0100) begin
            n_errors++;
            $display("FAIL busy_bus_grant: got %b required 0100 three cycles after release", bus_if.grant);
        end
        bus_if.request = 4'b0;
        wait_idle(ok, 20);
    endtask

    task automatic test_timeout();
        logic [3:0] g;
        int         cyc;
        bit         ok;
        bit         bad = 1'b0;
        wait_idle(ok, 20);
        bus_if.request = 4'b0110;
        push_exp(4'b0010, -1);
        push_exp(4'b0100, 4);
        wait_grant(g, cyc, 20);
        n_checks++;
        if (g !== 4'b0010 || cyc != 1) begin
            n_errors++;
            $display("FAIL to_first_grant: got %b after %0d cycles required 0010 after 1", g, cyc);
        end
        repeat (63) begin
            tick();
            if (bus_if.grant !== 4'b0010 || bus_if.timeout !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_errors++;
            $display("FAIL to_hold: got grant=%b timeout=%b required 0010/0 through hold 63",
                     bus_if.grant, bus_if.timeout);
        end
        tick();
        n_checks++;
        if (bus_if.grant !== 4'b0 || bus_if.timeout !== 1'b1 || bus_if.lockout !== 4'b0010) begin
            n_errors++;
            $display("FAIL to_revoke: got grant=%b timeout=%b lockout=%b required 0000/1/0010",
                     bus_if.grant, bus_if.timeout, bus_if.lockout);
        end
        tick();
        n_checks++;
        if (bus_if.timeout !== 1'b0) begin
            n_errors++;
            $display("FAIL to_pulse_width: got timeout=%b required 0", bus_if.timeout);
        end
        wait_grant(g, cyc, 20);
        n_checks++;
        if (g !== 4'b0100 || bus_if.lockout !== 4'b0010) begin
            n_errors++;
            $display("FAIL to_next_grant: got grant=%b lockout=%b required 0100/0010", g, bus_if.lockout);
        end
        bus_if.request = 4'b0010;
        bad = 1'b0;
        repeat (10) begin
            tick();
            if (bus_if.grant !== 4'b0 || bus_if.lockout !== 4'b0010 || bus_if.timeout !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_errors++;
            $display("FAIL to_lockout_hold: got grant=%b lockout=%b timeout=%b required 0000/0010/0",
                     bus_if.grant, bus_if.lockout, bus_if.timeout);
        end
        bus_if.request = 4'b0;
        tick();
        n_checks++;
        if (bus_if.lockout !== 4'b0) begin
            n_errors++;
            $display("FAIL to_lockout_clear: got %b required 0000", bus_if.lockout);
        end
    endtask

    task automatic test_release_at_limit();
        logic [3:0] g;
        int         cyc;
        bit         ok;
        bit         bad = 1'b0;
        wait_idle(ok, 20);
        bus_if.request = 4'b1000;
        push_exp(4'b1000, -1);
        wait_grant(g, cyc, 20);
        n_checks++;
        if (g !== 4'b1000) begin
            n_errors++;
            $display("FAIL limit_grant: got %b required 1000", g);
        end
        repeat (63) begin
            tick();
            if (bus_if.grant !== 4'b1000) bad = 1'b1;
        end
        bus_if.request = 4'b0;
        tick();
        n_checks++;
        if (bad || bus_if.grant !== 4'b0 || bus_if.timeout !== 1'b0 || bus_if.lockout !== 4'b0 ||
            bus_if.busy !== 1'b1) begin
            n_errors++;
            $display("FAIL limit_release: got hold_bad=%0b grant=%b timeout=%b lockout=%b busy=%b required 0/0000/0/0000/1",
                     bad, bus_if.grant, bus_if.timeout, bus_if.lockout, bus_if.busy);
        end
        bad = 1'b0;
        repeat (6) begin
            tick();
            if (bus_if.timeout !== 1'b0 || bus_if.lockout !== 4'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad || bus_if.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL limit_gap: got bad=%0b busy=%b required 0/0", bad, bus_if.busy);
        end
    endtask

    task automatic test_reset_mid_grant();
        logic [3:0] g;
        int         cyc;
        bit         ok;
        wait_idle(ok, 20);
        bus_if.request = 4'b0010;
        push_exp(4'b0010, -1);
        wait_grant(g, cyc, 20);
        n_checks++;
        if (g !== 4'b0010) begin
            n_errors++;
            $display("FAIL rst_pre_grant: got %b required 0010", g);
        end
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus_if.grant !== 4'b0 || bus_if.busy !== 1'b0 || bus_if.lockout !== 4'b0 ||
            bus_if.timeout !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_async: got grant=%b busy=%b lockout=%b timeout=%b required all zero",
                     bus_if.grant, bus_if.busy, bus_if.lockout, bus_if.timeout);
        end
        bus_if.request = 4'b0110;
        tick();
        tick();
        reset_n = 1'b1;
        push_exp(4'b0010, -1);
        tick();
        n_checks++;
        if (bus_if.grant !== 4'b0010) begin
            n_errors++;
            $display("FAIL rst_priority: got %b required 0010", bus_if.grant);
        end
        bus_if.request = 4'b0;
        wait_idle(ok, 20);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_bus_busy();
        test_timeout();
        test_release_at_limit();
        test_reset_mid_grant();
        repeat (2) tick();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL sb_drain: got %0d pending grants required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
